// File: rtl/det_seq_pkg.sv
// Shared types and defaults for the serial pattern detector controller.
package det_seq_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int PAT_W_DEF  = 4;
  localparam int CNT_W_DEF  = 16;
  localparam int BIT_IDX_W  = $clog2(WORD_W_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // Bit-index width that stays legal even for a 1-bit word.
  function automatic int idx_width(int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/det_seq_window.sv
// PAT_W-bit detection window with fill count and overlap control.
// hit_o is combinational on the incoming bit; match_o is the registered pulse one cycle later.
module det_seq_window
  import det_seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr_i,
  input  logic             bit_vld_i,
  input  logic             bit_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic             overlap_i,
  output logic             hit_o,
  output logic             match_o
);

  localparam int FW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] hist_q, hist_d, hist_shift;
  logic [FW-1:0]    fill_q, fill_d, fill_inc;
  logic             match_q;
  logic             hit;

  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], bit_i};
    fill_inc   = (fill_q == FW'(PAT_W)) ? fill_q : fill_q + FW'(1);
    hit        = bit_vld_i && (fill_inc == FW'(PAT_W)) && (hist_shift == pattern_i);
    hist_d     = hist_q;
    fill_d     = fill_q;
    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_vld_i) begin
      hist_d = hist_shift;
      // Without overlap the next match must be built from PAT_W fresh bits.
      fill_d = (hit && !overlap_i) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= hit && !clr_i;
    end
  end

  assign hit_o   = hit && !clr_i;
  assign match_o = match_q;

endmodule

// File: rtl/det_seq_ctrl.sv
// Word-to-bit scheduler, match counter and threshold halt around det_seq_window.
// Word accepted in T shows MSB in T+1; s_ready_o only in ARMED, so one word per WORD_W+1 cycles.
module det_seq_ctrl
  import det_seq_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int PAT_W  = PAT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [PAT_W-1:0]  cfg_pattern_i,
  input  logic              cfg_overlap_i,
  input  logic [CNT_W-1:0]  cfg_thresh_i,
  input  logic              s_valid_i,
  input  logic [WORD_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic              bit_valid_o,
  output logic              bit_out_o,
  output logic              match_o,
  output logic [CNT_W-1:0]  match_cnt_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              irq_o
);

  localparam int IW = idx_width(WORD_W);

  state_e            state_q;
  logic [WORD_W-1:0] word_q;
  logic [IW-1:0]     idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              s_ready_q, bit_valid_q, bit_out_q, busy_q, done_q, irq_q;

  logic              hit, win_vld, do_start, thr_hit;
  logic [CNT_W-1:0]  cnt_inc;

  // A bit presented in the same cycle as stop is discarded, so it never scores.
  assign win_vld  = bit_valid_q && !stop_i;
  assign do_start = start_i && !stop_i && (state_q == ST_IDLE || state_q == ST_HALT);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign thr_hit  = hit && (cfg_thresh_i != '0) && (cnt_inc == cfg_thresh_i);

  det_seq_window #(.PAT_W(PAT_W)) u_window (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clr_i     (do_start),
    .bit_vld_i (win_vld),
    .bit_i     (bit_out_q),
    .pattern_i (cfg_pattern_i),
    .overlap_i (cfg_overlap_i),
    .hit_o     (hit),
    .match_o   (match_o)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      s_ready_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (hit) cnt_q <= cnt_inc;
      if (stop_i) begin
        state_q     <= ST_IDLE;
        s_ready_q   <= 1'b0;
        bit_valid_q <= 1'b0;
        busy_q      <= 1'b0;
        done_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_HALT: begin
            if (start_i) begin
              state_q   <= ST_ARMED;
              cnt_q     <= '0;
              s_ready_q <= 1'b1;
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
            end
          end
          ST_ARMED: begin
            if (s_valid_i) begin
              state_q     <= ST_SHIFT;
              s_ready_q   <= 1'b0;
              word_q      <= s_data_i << 1;
              bit_out_q   <= s_data_i[WORD_W-1];
              bit_valid_q <= 1'b1;
              idx_q       <= '0;
            end
          end
          ST_SHIFT: begin
            if (thr_hit) begin
              state_q     <= ST_HALT;
              bit_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              irq_q       <= 1'b1;
            end else if (idx_q == IW'(WORD_W - 1)) begin
              state_q     <= ST_ARMED;
              bit_valid_q <= 1'b0;
              s_ready_q   <= 1'b1;
            end else begin
              bit_out_q <= word_q[WORD_W-1];
              word_q    <= word_q << 1;
              idx_q     <= idx_q + IW'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign s_ready_o   = s_ready_q;
  assign bit_valid_o = bit_valid_q;
  assign bit_out_o   = bit_out_q;
  assign match_cnt_o = cnt_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_det_seq_ctrl.sv
// Bench for det_seq_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_det_seq_ctrl;

  localparam int WORD_W  = 8;
  localparam int PAT_W   = 4;
  localparam int CNT_W   = 16;
  localparam int CNT_S   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int CNT_SMX = (1 << CNT_S) - 1;
  localparam int M_IDLE = 0, M_READY = 1, M_STREAM = 2, M_HALT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn, start, stop, s_valid, cfg_overlap;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [CNT_W-1:0]  cfg_thresh;
  logic [CNT_S-1:0]  thresh_s;
  logic [WORD_W-1:0] s_data;

  logic             s_ready, bit_valid, bit_out, match, busy, done, irq;
  logic [CNT_W-1:0] match_cnt;
  logic             s_ready_s, bit_valid_s, bit_out_s, match_s, busy_s, done_s, irq_s;
  logic [CNT_S-1:0] match_cnt_s;

  det_seq_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .stop_i(stop),
    .cfg_pattern_i(cfg_pattern), .cfg_overlap_i(cfg_overlap), .cfg_thresh_i(cfg_thresh),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
    .bit_valid_o(bit_valid), .bit_out_o(bit_out), .match_o(match),
    .match_cnt_o(match_cnt), .busy_o(busy), .done_o(done), .irq_o(irq)
  );

  // Narrow-counter twin, threshold disabled, used to observe saturation.
  det_seq_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_S)) dut_s (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .stop_i(stop),
    .cfg_pattern_i(cfg_pattern), .cfg_overlap_i(cfg_overlap), .cfg_thresh_i(thresh_s),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready_s),
    .bit_valid_o(bit_valid_s), .bit_out_o(bit_out_s), .match_o(match_s),
    .match_cnt_o(match_cnt_s), .busy_o(busy_s), .done_o(done_s), .irq_o(irq_s)
  );

  int n_chk = 0;
  int n_err = 0;
  bit sm_on = 1'b0;

  // Reference model: mode, bits still to emit, recent window bits since last clear.
  int m_mode;
  bit e_vld, e_bit, e_match, e_irq;
  int m_cnt, m_raw;
  bit m_pend[$];
  bit m_recent[$];

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; e_vld = 0; e_bit = 0; e_match = 0; e_irq = 0;
    m_cnt = 0; m_raw = 0;
    m_pend.delete(); m_recent.delete();
  endtask

  task automatic model_step(bit st, bit sp, bit v, logic [WORD_W-1:0] d);
    bit hit;
    int val;
    hit = 0;
    e_match = 0;
    e_irq = 0;
    if (sp) begin
      m_mode = M_IDLE; e_vld = 0; m_pend.delete();
      return;
    end
    if (e_vld) begin
      m_recent.push_back(e_bit);
      if (m_recent.size() > PAT_W) void'(m_recent.pop_front());
      if (m_recent.size() == PAT_W) begin
        val = 0;
        foreach (m_recent[i]) val = val * 2 + int'(m_recent[i]);
        hit = (val == int'(cfg_pattern));
      end
      if (hit) begin
        e_match = 1;
        m_raw++;
        if (m_cnt < CNT_MAX) m_cnt++;
        if (!cfg_overlap) m_recent.delete();
      end
    end
    e_vld = 0;
    case (m_mode)
      M_IDLE, M_HALT: if (st) begin
        m_mode = M_READY; m_cnt = 0; m_raw = 0; m_recent.delete();
      end
      M_READY: if (v) begin
        for (int i = 0; i < WORD_W; i++) m_pend.push_back(d[WORD_W-1-i]);
        m_mode = M_STREAM;
        e_bit = m_pend.pop_front();
        e_vld = 1;
      end
      default: begin
        if (hit && cfg_thresh != 0 && m_cnt == int'(cfg_thresh)) begin
          m_mode = M_HALT; m_pend.delete(); e_irq = 1;
        end else if (m_pend.size() == 0) begin
          m_mode = M_READY;
        end else begin
          e_bit = m_pend.pop_front();
          e_vld = 1;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    int sat;
    check_eq("s_ready", s_ready, m_mode == M_READY);
    check_eq("busy", busy, m_mode == M_READY || m_mode == M_STREAM);
    check_eq("done", done, m_mode == M_HALT);
    check_eq("irq", irq, e_irq);
    check_eq("match", match, e_match);
    check_eq("bit_valid", bit_valid, e_vld);
    check_eq("match_cnt", match_cnt, m_cnt);
    if (e_vld) check_eq("bit_out", bit_out, e_bit);
    if (sm_on) begin
      sat = (m_raw > CNT_SMX) ? CNT_SMX : m_raw;
      check_eq("s_match_cnt", match_cnt_s, sat);
      check_eq("s_bit_valid", bit_valid_s, e_vld);
      check_eq("s_match", match_s, e_match);
      check_eq("s_ready_s", s_ready_s, m_mode == M_READY);
      check_eq("s_busy", busy_s, m_mode == M_READY || m_mode == M_STREAM);
      check_eq("s_done_irq", {done_s, irq_s}, 0);
      if (e_vld) check_eq("s_bit_out", bit_out_s, e_bit);
    end
  endtask

  // Called at a negedge: check this cycle's outputs, drive inputs, advance one cycle.
  task automatic tick(bit st, bit sp, bit v, logic [WORD_W-1:0] d);
    compare_all();
    start = st; stop = sp; s_valid = v; s_data = d;
    model_step(st, sp, v, d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 0; start = 0; stop = 0; s_valid = 0; s_data = '0;
    #1;
    check_eq("rst_outs", {s_ready, bit_valid, bit_out, match, busy, done, irq}, 0);
    check_eq("rst_cnt", match_cnt, 0);
    check_eq("rst_outs_s", {s_ready_s, bit_valid_s, bit_out_s, match_s, busy_s, done_s, irq_s}, 0);
    check_eq("rst_cnt_s", match_cnt_s, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic restart(logic [PAT_W-1:0] pat, bit ovl, logic [CNT_W-1:0] thr);
    tick(0, 1, 0, '0);
    cfg_pattern = pat; cfg_overlap = ovl; cfg_thresh = thr;
    tick(1, 0, 0, '0);
  endtask

  // Offers a word until accepted at T, then records match/irq/bit_valid at T+1..T+WORD_W+1.
  task automatic send_word(logic [WORD_W-1:0] d, output logic [15:0] mpos,
                           output logic [15:0] ipos, output logic [15:0] vpos);
    bit acc;
    acc = 0; mpos = '0; ipos = '0; vpos = '0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = (m_mode == M_READY);
      tick(0, 0, 1, d);
    end
    check_eq("accept_in_time", acc, 1);
    for (int k = 1; k <= WORD_W + 1; k++) begin
      mpos[k] = match; ipos[k] = irq; vpos[k] = bit_valid;
      if (k <= WORD_W) tick(0, 0, 0, '0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mp, ip, vp, mp2;
    cfg_pattern = 4'b1011; cfg_overlap = 0; cfg_thresh = '0; thresh_s = '0;
    do_reset();
    tick(0, 0, 0, '0);
    tick(0, 0, 0, '0);

    // Non-overlap: single match at T+5.
    tick(1, 0, 0, '0);
    send_word(8'hB6, mp, ip, vp);
    check_eq("novl_mpos", mp, 16'h0020);
    check_eq("novl_vpos", vp, 16'h01FE);
    check_eq("novl_cnt", match_cnt, 1);

    // Overlap: matches at T+5 and T+8.
    restart(4'b1011, 1, '0);
    send_word(8'hB6, mp, ip, vp);
    check_eq("ovl_mpos", mp, 16'h0120);
    check_eq("ovl_cnt", match_cnt, 2);

    // Threshold 2: halt at T+8, last bit dropped.
    restart(4'b1011, 1, 16'd2);
    send_word(8'hB6, mp, ip, vp);
    check_eq("thr_ipos", ip, 16'h0100);
    check_eq("thr_vpos", vp, 16'h00FE);
    check_eq("thr_done", done, 1);
    check_eq("thr_ready", s_ready, 0);
    tick(1, 0, 0, '0);
    check_eq("thr_restart_cnt", match_cnt, 0);
    check_eq("thr_restart_rdy", s_ready, 1);

    // Pattern straddling two words.
    restart(4'b1011, 1, '0);
    send_word(8'h01, mp, ip, vp);
    send_word(8'h60, mp2, ip, vp);
    check_eq("xw_first", mp[8:1], 0);
    check_eq("xw_second", mp2, 16'h0010);
    check_eq("xw_cnt", match_cnt, 1);

    // stop+start together mid-word: stop wins, count held.
    restart(4'b1011, 1, '0);
    tick(0, 0, 1, 8'hB6);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, '0);
    tick(1, 1, 0, '0);
    check_eq("ss_bit_valid", bit_valid, 0);
    check_eq("ss_busy", busy, 0);
    check_eq("ss_cnt", match_cnt, 1);
    tick(0, 0, 0, '0);

    // Reset asserted while shifting.
    tick(1, 0, 0, '0);
    tick(0, 0, 1, 8'hB6);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, '0);
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) tick(0, 0, 0, '0);
    check_eq("post_rst_rdy", s_ready, 0);

    // Random traffic; configuration only changes while not busy.
    for (int it = 0; it < 1500; it++) begin
      if ((m_mode == M_IDLE || m_mode == M_HALT) && $urandom_range(0, 3) == 0) begin
        cfg_pattern = PAT_W'($urandom);
        cfg_overlap = 1'($urandom);
        cfg_thresh  = ($urandom_range(0, 2) == 0) ? '0 : CNT_W'($urandom_range(1, 6));
      end
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 3) != 0, WORD_W'($urandom));
    end

    // Saturation on the narrow twin: 5 + 8 + 8 overlapping matches of 1111.
    restart(4'b1111, 1, '0);
    sm_on = 1;
    for (int w = 0; w < 3; w++) send_word(8'hFF, mp, ip, vp);
    check_eq("sat_cnt_s", match_cnt_s, 15);
    check_eq("sat_cnt", match_cnt, 21);
    tick(0, 0, 0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
